// File: rtl/fixed_point_divider.sv
// Sequential signed divider: INPUT_WIDTH-bit dividend by DATA_WIDTH-bit divisor,
// radix-2 restoring core, saturating quotient, start/done handshake.
module fixed_point_divider #(
    parameter int DATA_WIDTH  = 16,
    parameter int INPUT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INPUT_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]  divisor,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  quotient,
    output logic [DATA_WIDTH-1:0]  remainder,
    output logic                   overflow,
    output logic                   div_by_zero,
    output logic                   done
);

    localparam int CW = $clog2(INPUT_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0]  MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [INPUT_WIDTH-1:0] LIM_POS = INPUT_WIDTH'(MAX_POS);
    localparam logic [INPUT_WIDTH-1:0] LIM_NEG = INPUT_WIDTH'(MIN_NEG);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0]  dsr;
    logic [DATA_WIDTH-1:0]  rem;
    logic [CW-1:0]          count;
    logic                   sign_q;
    logic                   sign_r;
    logic                   dz;

    logic [INPUT_WIDTH-1:0] dvd_abs;
    logic [DATA_WIDTH-1:0]  dsr_abs;
    logic [DATA_WIDTH:0]    shifted;
    logic [DATA_WIDTH:0]    diff;

    // q_reg shifts dividend bits out of its MSB while quotient bits fill its LSB.
    always_comb begin
        dvd_abs = dividend[INPUT_WIDTH-1] ? -dividend : dividend;
        dsr_abs = divisor[DATA_WIDTH-1] ? -divisor : divisor;
        shifted = {rem, q_reg[INPUT_WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            q_reg       <= '0;
            dsr         <= '0;
            rem         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg  <= dvd_abs;
                        dsr    <= dsr_abs;
                        rem    <= '0;
                        count  <= CW'(INPUT_WIDTH);
                        sign_q <= dividend[INPUT_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                        sign_r <= dividend[INPUT_WIDTH-1];
                        dz     <= (divisor == '0);
                        busy   <= 1'b1;
                        state  <= (divisor == '0) ? FINISH : DIVIDE;
                    end
                end
                DIVIDE: begin
                    // Partial remainder stays below |divisor|, so DATA_WIDTH bits hold it.
                    if (!diff[DATA_WIDTH]) begin
                        rem   <= diff[DATA_WIDTH-1:0];
                        q_reg <= {q_reg[INPUT_WIDTH-2:0], 1'b1};
                    end else begin
                        rem   <= shifted[DATA_WIDTH-1:0];
                        q_reg <= {q_reg[INPUT_WIDTH-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    if (dz) begin
                        quotient    <= sign_r ? MIN_NEG : MAX_POS;
                        remainder   <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        if (q_reg > (sign_q ? LIM_NEG : LIM_POS)) begin
                            quotient <= sign_q ? MIN_NEG : MAX_POS;
                            overflow <= 1'b1;
                        end else begin
                            quotient <= sign_q ? -q_reg[DATA_WIDTH-1:0] : q_reg[DATA_WIDTH-1:0];
                            overflow <= 1'b0;
                        end
                        remainder   <= sign_r ? -rem : rem;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed-vector bench for fixed_point_divider with hand-computed expectations.
module tb_fixed_point_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        overflow;
    logic        div_by_zero;
    logic        done;

    int checks = 0;
    int errors = 0;

    fixed_point_divider #(.DATA_WIDTH(16), .INPUT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend),
        .divisor(divisor), .busy(busy), .quotient(quotient), .remainder(remainder),
        .overflow(overflow), .div_by_zero(div_by_zero), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents operands with start for one clock; returns just after the accepting edge.
    task automatic do_start(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; bounded so a missing done cannot hang the run.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic eo, input logic ez, input int elat);
        int lat;
        do_start(a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_dz"}, div_by_zero, ez);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int lat;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_ovf", overflow, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Inverse of 0x0180 * 0xFE00
        run("inv", 32'hFFFD0000, 16'hFE00, 16'h0180, 16'h0000, 0, 0, 33);
        @(posedge clk); #1;
        check("inv_pulse", done, 0);
        check("inv_hold", quotient, 16'h0180);

        run("p_n", 32'd100, -16'sd7, 16'hFFF2, 16'h0002, 0, 0, 33);
        run("n_p", -32'sd100, 16'd7, 16'hFFF2, 16'hFFFE, 0, 0, 33);
        run("n_n", -32'sd100, -16'sd7, 16'h000E, 16'hFFFE, 0, 0, 33);

        run("sat_pos", 32'h7FFFFFFF, 16'd1, 16'h7FFF, 16'h0000, 1, 0, 33);
        run("sat_min", 32'h80000000, 16'hFFFF, 16'h7FFF, 16'h0000, 1, 0, 33);
        run("min_ok", 32'hFFFF8000, 16'd1, 16'h8000, 16'h0000, 0, 0, 33);

        run("dz_neg", -32'sd5, 16'd0, 16'h8000, 16'h0000, 0, 1, 1);
        run("dz_pos", 32'd5, 16'd0, 16'h7FFF, 16'h0000, 0, 1, 1);

        // start pulsed in the middle of a divide must be ignored
        do_start(32'd100, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        do_start(32'd1, 16'd1);
        wait_done(lat);
        check("ign_lat", lat + 5, 33);
        check("ign_q", quotient, 16'h000E);
        check("ign_r", remainder, 16'h0002);
        count_dones(40, n);
        check("ign_extra_done", n, 0);

        // start held during the done cycle is accepted
        do_start(32'd100, 16'd7);
        wait_done(lat);
        check("b2b_first_q", quotient, 16'h000E);
        dividend = -32'sd100;
        divisor  = -16'sd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(lat);
        check("b2b_lat", lat, 33);
        check("b2b_q", quotient, 16'h000E);
        check("b2b_r", remainder, 16'hFFFE);

        // mid-operation reset aborts with no done
        do_start(32'd100, 16'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_flags", {overflow, div_by_zero, done}, 0);
        @(negedge clk);
        reset = 1'b0;
        count_dones(40, n);
        check("abort_no_done", n, 0);
        run("after_rst", 32'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
